uart_mem_master: RTL and testbench
==================================

# uart_mem_master

UART-driven initiator on the native picorv32-style memory bus (`mem_valid`/`mem_ready`/`mem_addr`/`mem_wdata`/`mem_wstrb`/`mem_rdata`). It parses command frames from the `uart_rx` byte interface and issues single-word read or write transactions into the RAM/IO address space. It returns the results through the `uart_tx` byte interface. It is the bus-master counterpart of the RAM and `io` responders and is used for host download and debug access.

## Interface
Parameters:
- `TIMEOUT`, 1024: cycles `mem_valid` may stay high without `mem_ready` before the transaction is abandoned (≥2).

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `rx_data`  in  8  received byte from `uart_rx`.
- `rx_ready`  in  1  byte available in `uart_rx`.
- `rx_ack`  out  1  one-cycle read strobe that consumes the byte.
- `tx_data`  out  8  byte to transmit.
- `tx_start`  out  1  one-cycle write strobe to `uart_tx`.
- `tx_ready`  in  1  `uart_tx` idle. Drops the cycle after `tx_start` and stays low until the byte has been shifted out.
- `mem_valid`  out  1  transaction request.
- `mem_addr`  out  32  word address; bits [1:0] are always 0.
- `mem_wdata`  out  32  write data.
- `mem_wstrb`  out  4  4'hF for writes, 4'h0 for reads.
- `mem_ready`  in  1  responder completion; `mem_rdata` is valid in the same cycle.
- `mem_rdata`  in  32  read data.
- `busy`  out  1  high in every state except IDLE.

## Operation
- Frame format:
  - Command byte, then 4 address bytes, MSB first.
  - `0x57` ('W'): 4 further data bytes follow, MSB first.
  - `0x52` ('R'): no data bytes.
  - Any other command byte is consumed and discarded; the FSM stays in IDLE.
- States:
  - IDLE: wait for a command byte. 'W' or 'R' → ADDR with byte counter = 0.
  - ADDR: shift bytes into the address register. After the 4th byte: 'W' → DATA, 'R' → BUS.
  - DATA: shift 4 bytes into the wdata register, then → BUS.
  - BUS: drive `mem_valid`=1 with stable addr/wdata/wstrb.
    - `mem_ready`=1 → capture `mem_rdata` and → RESP.
    - Timeout counter reaches `TIMEOUT` → → RESP with error flag set.
  - RESP: send the response bytes, then → IDLE.
- Responses:
  - Write OK: `0x4B` ('K').
  - Read OK: 4 data bytes, MSB first.
  - Timeout (read or write): `0x45` ('E') only.
- `mem_addr[1:0]` forced to 0 regardless of the received bytes.
- Byte receive rule: `rx_ack` = receive state && `rx_ready` && !`rx_ack` (previous cycle). `rx_data` is sampled in the cycle `rx_ack` is high.
- Byte transmit rule: `tx_start` pulses when in RESP and `tx_ready` is high, but not in the cycle immediately after a `tx_start`. `tx_data` is stable from `tx_start` until the next byte is loaded.
- `rx_ready` is ignored in BUS and RESP. Bytes arriving then stay in `uart_rx` until IDLE.
- Reset mid-frame or mid-transaction:
  - All state clears immediately, asynchronously.
  - A partial frame is discarded and no response is sent.

## Timing
- Reset values: `rx_ack`=0, `tx_start`=0, `tx_data`=0, `mem_valid`=0, `mem_addr`=0, `mem_wdata`=0, `mem_wstrb`=0, `busy`=0. FSM = IDLE, counters = 0.
- `mem_valid` rises in the cycle after the last frame byte's `rx_ack`.
- `mem_valid` falls in the cycle after `mem_ready` is sampled high. It is never high on the cycle after `mem_ready`.
- A same-cycle response (`mem_ready` in the first `mem_valid` cycle) is legal: the bus phase lasts 1 cycle.
- Timeout: `mem_valid` is high for exactly `TIMEOUT` cycles, then drops.
- `mem_ready` arriving in the same cycle as the timeout expiry counts as success.
- First `tx_start` occurs no earlier than 1 cycle after entering RESP.
- `busy` falls in the cycle after the last response byte's `tx_start`.
- Throughput: one transaction in flight; no pipelining.

## Test plan
- Write: rx `57 00 00 01 00 DE AD BE EF`, responder `mem_ready` on the 1st cycle → one bus cycle with addr 0x00000100, wdata 0xDEADBEEF, wstrb F; tx `4B`.
- Read: rx `52 00 00 01 03`, `mem_ready` after 3 cycles with rdata 0x12345678 → addr 0x00000100, wstrb 0, `mem_valid` high for 3 cycles; tx `12 34 56 78`.
- Timeout: rx `52 80 00 00 08`, `mem_ready` never asserted, `TIMEOUT`=16 → `mem_valid` high exactly 16 cycles; tx `45`; FSM returns to IDLE.
- Junk and back-pressure: rx `00 FF 52 …`, with `tx_ready` held low for 100 cycles during RESP → both junk bytes are acked with no bus activity; the read completes; `tx_start` waits for `tx_ready`; no byte is dropped or duplicated.
- Reset mid-frame: assert `reset` after 3 bytes of a 'W' frame, then send a full 'R' frame → no write issued, no response to the partial frame; the read completes normally.
- `rx_ready` held continuously high → `rx_ack` pulses on at most every other cycle; 9-byte frame consumed in exactly 9 acks.

Source files
------------

// File: rtl/uart_mem_master.sv
// UART command-frame bus master: parses 'W'/'R' frames from a byte receiver, runs one
// single-word transaction on the native memory bus and replies through the byte transmitter.
module uart_mem_master #(
    parameter int TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_ready,
    output logic        rx_ack,
    output logic [7:0]  tx_data,
    output logic        tx_start,
    input  logic        tx_ready,
    output logic        mem_valid,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        busy
);
    localparam int            CW       = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);
    localparam logic [7:0]    CMD_W    = 8'h57;
    localparam logic [7:0]    CMD_R    = 8'h52;
    localparam logic [7:0]    RSP_K    = 8'h4B;
    localparam logic [7:0]    RSP_E    = 8'h45;

    typedef enum logic [2:0] {IDLE, ADDR, DATA, BUS, RESP} state_t;

    state_t        state;
    logic          is_write;
    logic          err;
    logic [1:0]    byte_cnt;
    logic [2:0]    tx_cnt;
    logic [CW-1:0] tmo_cnt;
    logic [31:0]   rdata_reg;
    logic          receiving;
    logic [2:0]    resp_len;
    logic [7:0]    resp_byte;

    assign receiving = (state == IDLE) || (state == ADDR) || (state == DATA);

    // Response is a single status byte for writes and errors, else the read word MSB first.
    always_comb begin
        resp_len  = (err || is_write) ? 3'd1 : 3'd4;
        resp_byte = rdata_reg[31:24];
        if (err) begin
            resp_byte = RSP_E;
        end else if (is_write) begin
            resp_byte = RSP_K;
        end else begin
            case (tx_cnt[1:0])
                2'd0:    resp_byte = rdata_reg[31:24];
                2'd1:    resp_byte = rdata_reg[23:16];
                2'd2:    resp_byte = rdata_reg[15:8];
                default: resp_byte = rdata_reg[7:0];
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            is_write  <= 1'b0;
            err       <= 1'b0;
            byte_cnt  <= '0;
            tx_cnt    <= '0;
            tmo_cnt   <= '0;
            rdata_reg <= '0;
            rx_ack    <= 1'b0;
            tx_data   <= '0;
            tx_start  <= 1'b0;
            mem_valid <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
            busy      <= 1'b0;
        end else begin
            // Ack is never issued on consecutive cycles, so the receiver has time to drop rx_ready.
            rx_ack   <= receiving && rx_ready && !rx_ack;
            tx_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (rx_ack && (rx_data == CMD_W || rx_data == CMD_R)) begin
                        is_write <= (rx_data == CMD_W);
                        byte_cnt <= '0;
                        busy     <= 1'b1;
                        state    <= ADDR;
                    end
                end
                ADDR: begin
                    if (rx_ack) begin
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            mem_addr <= {mem_addr[23:0], rx_data[7:2], 2'b00};
                            if (is_write) begin
                                state <= DATA;
                            end else begin
                                mem_valid <= 1'b1;
                                mem_wstrb <= 4'h0;
                                tmo_cnt   <= '0;
                                state     <= BUS;
                            end
                        end else begin
                            mem_addr <= {mem_addr[23:0], rx_data};
                        end
                    end
                end
                DATA: begin
                    if (rx_ack) begin
                        mem_wdata <= {mem_wdata[23:0], rx_data};
                        byte_cnt  <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            mem_valid <= 1'b1;
                            mem_wstrb <= 4'hF;
                            tmo_cnt   <= '0;
                            state     <= BUS;
                        end
                    end
                end
                BUS: begin
                    // A completion in the final timeout cycle still wins over the error.
                    if (mem_ready) begin
                        rdata_reg <= mem_rdata;
                        err       <= 1'b0;
                        mem_valid <= 1'b0;
                        mem_wstrb <= 4'h0;
                        tx_cnt    <= '0;
                        state     <= RESP;
                    end else if (tmo_cnt == TMO_LAST) begin
                        err       <= 1'b1;
                        mem_valid <= 1'b0;
                        mem_wstrb <= 4'h0;
                        tx_cnt    <= '0;
                        state     <= RESP;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                RESP: begin
                    if (!tx_start && tx_ready && tx_cnt != resp_len) begin
                        tx_start <= 1'b1;
                        tx_data  <= resp_byte;
                        tx_cnt   <= tx_cnt + 3'd1;
                    end else if (tx_start && tx_cnt == resp_len) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_mem_master.sv
// Randomized bench for uart_mem_master: byte-level UART and bus responder models plus a
// transaction-level expectation queue derived from the frames sent.
module tb_uart_mem_master;
    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_ready = 1'b0;
    logic        rx_ack;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_ready = 1'b1;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata = 32'h0;
    logic        busy;

    uart_mem_master #(.TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset),
        .rx_data(rx_data), .rx_ready(rx_ready), .rx_ack(rx_ack),
        .tx_data(tx_data), .tx_start(tx_start), .tx_ready(tx_ready),
        .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          lat;     // valid cycle on which ready is given; <=0 means never
        logic [31:0] rdata;
    } txn_t;

    typedef struct {
        logic [7:0] b;
        bit         last;
    } tx_exp_t;

    int          cmp_n = 0;
    int          fail_n = 0;
    logic [7:0]  rx_q[$];
    txn_t        plan_q[$];
    tx_exp_t     exp_tx[$];
    logic [7:0]  tx_log[$];
    bit          frame_end[int];
    int          n_pushed = 0;
    int          n_acks = 0;
    int          bus_count = 0;
    int          rx_gap = 30;
    int          tx_dmax = 4;
    bit          hold_tx = 0;
    bit          presenting, rx_pend, ack_prev, expect_rise;
    bit          drop_pend, txs_prev, expect_idle, prev_valid, have_cur;
    int          tx_cnt, vcnt, last_len;
    txn_t        cur;
    tx_exp_t     e;
    logic [31:0] last_addr, last_wdata;
    logic [3:0]  last_wstrb;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmp_n++;
        if (act !== exp) begin
            fail_n++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int explen(input int lat);
        return (lat >= 1 && lat <= TMO) ? lat : TMO;
    endfunction

    task automatic send_frame(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                              input int lat, input logic [31:0] rdata);
        txn_t       t;
        tx_exp_t    x;
        logic [7:0] b[$];
        b.push_back(we ? 8'h57 : 8'h52);
        for (int i = 3; i >= 0; i--) b.push_back(addr[8*i +: 8]);
        if (we) for (int i = 3; i >= 0; i--) b.push_back(wdata[8*i +: 8]);
        t.we = we; t.addr = {addr[31:2], 2'b00}; t.wdata = wdata; t.lat = lat; t.rdata = rdata;
        plan_q.push_back(t);
        if (lat < 1 || lat > TMO) begin
            x.b = 8'h45; x.last = 1; exp_tx.push_back(x);
        end else if (we) begin
            x.b = 8'h4B; x.last = 1; exp_tx.push_back(x);
        end else begin
            for (int i = 3; i >= 0; i--) begin
                x.b = rdata[8*i +: 8]; x.last = (i == 0); exp_tx.push_back(x);
            end
        end
        foreach (b[i]) rx_q.push_back(b[i]);
        frame_end[n_pushed + b.size() - 1] = 1;
        n_pushed += b.size();
    endtask

    task automatic send_junk(input logic [7:0] v);
        rx_q.push_back(v);
        n_pushed++;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (n < budget && !(rx_q.size() == 0 && plan_q.size() == 0 && exp_tx.size() == 0
                               && !busy && !mem_valid)) begin
            @(negedge clk);
            n++;
        end
        chk("idle_reached", 32'(n < budget), 32'd1);
        repeat (3) @(negedge clk);
    endtask

    // Single compare/drive process: UART receiver, UART transmitter and bus responder models.
    always @(negedge clk) begin
        if (reset) begin
            rx_ready = 1'b0; rx_data = 8'h00; presenting = 0; rx_pend = 0; ack_prev = 0;
            expect_rise = 0; tx_ready = 1'b1; drop_pend = 0; tx_cnt = 0; txs_prev = 0;
            expect_idle = 0; mem_ready = 1'b0; prev_valid = 0; vcnt = 0; have_cur = 0;
        end else begin
            if (expect_rise) begin
                chk("valid_rise", {30'd0, prev_valid, mem_valid}, 32'd1);
                expect_rise = 0;
            end
            if (rx_ack) begin
                chk("rx_ack_gap", 32'(ack_prev), 32'd0);
                chk("rx_ack_ready", 32'(presenting), 32'd1);
                if (frame_end.exists(n_acks)) expect_rise = 1;
                n_acks++;
            end
            if (rx_pend) begin
                void'(rx_q.pop_front());
                presenting = 0;
                rx_pend = 0;
            end
            if (rx_ack && presenting) rx_pend = 1;
            if (!presenting && rx_q.size() > 0 && $urandom_range(99) >= rx_gap) presenting = 1;
            rx_ready = presenting;
            rx_data = presenting ? rx_q[0] : 8'h00;

            if (mem_valid) begin
                if (!prev_valid) begin
                    vcnt = 0;
                    bus_count++;
                    last_addr = mem_addr; last_wdata = mem_wdata; last_wstrb = mem_wstrb;
                    have_cur = plan_q.size() > 0;
                    chk("bus_expected", 32'(have_cur), 32'd1);
                    if (have_cur) cur = plan_q.pop_front();
                end
                vcnt++;
                chk("busy_in_bus", 32'(busy), 32'd1);
                if (have_cur) begin
                    chk("bus_addr", mem_addr, cur.addr);
                    chk("bus_wstrb", 32'(mem_wstrb), cur.we ? 32'hF : 32'h0);
                    if (cur.we) chk("bus_wdata", mem_wdata, cur.wdata);
                end
                mem_ready = have_cur && (vcnt == cur.lat);
                mem_rdata = mem_ready ? cur.rdata : $urandom();
            end else begin
                if (prev_valid && have_cur) begin
                    chk("bus_len", 32'(vcnt), 32'(explen(cur.lat)));
                    last_len = vcnt;
                end
                mem_ready = 1'b0;
                mem_rdata = $urandom();
            end
            prev_valid = mem_valid;

            if (expect_idle) begin
                chk("busy_fall", 32'(busy), 32'd0);
                expect_idle = 0;
            end
            if (tx_start) begin
                chk("tx_gap", 32'(txs_prev), 32'd0);
                chk("tx_when_ready", 32'(tx_ready), 32'd1);
                chk("busy_at_tx", 32'(busy), 32'd1);
                chk("tx_expected", 32'(exp_tx.size() > 0), 32'd1);
                if (exp_tx.size() > 0) begin
                    e = exp_tx.pop_front();
                    chk("tx_byte", 32'(tx_data), 32'(e.b));
                    if (e.last) expect_idle = 1;
                end
                tx_log.push_back(tx_data);
            end
            if (drop_pend) begin
                tx_ready = 1'b0;
                tx_cnt = $urandom_range(tx_dmax, 1);
                drop_pend = 0;
            end else if (hold_tx) begin
                tx_ready = 1'b0;
            end else if (!tx_ready) begin
                if (tx_cnt > 0) tx_cnt--;
                else tx_ready = 1'b1;
            end
            if (tx_start) drop_pend = 1;
            txs_prev = tx_start;
            ack_prev = rx_ack;
        end
    end

    initial begin
        int n0, b0, n;
        logic [7:0] jb;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rx_ack", 32'(rx_ack), 32'd0);
        chk("rst_tx_start", 32'(tx_start), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        chk("rst_mem_valid", 32'(mem_valid), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        #2 reset = 1'b0;

        // Write, ready on the first bus cycle
        tx_log.delete();
        send_frame(1, 32'h0000_0100, 32'hDEAD_BEEF, 1, 32'h0);
        wait_idle(500);
        chk("wr_addr", last_addr, 32'h0000_0100);
        chk("wr_wdata", last_wdata, 32'hDEAD_BEEF);
        chk("wr_wstrb", 32'(last_wstrb), 32'hF);
        chk("wr_len", 32'(last_len), 32'd1);
        chk("wr_resp_n", 32'(tx_log.size()), 32'd1);
        if (tx_log.size() >= 1) chk("wr_resp", 32'(tx_log[0]), 32'h4B);

        // Read with low address bits set, ready on the third cycle
        tx_log.delete();
        send_frame(0, 32'h0000_0103, 32'h0, 3, 32'h1234_5678);
        wait_idle(500);
        chk("rd_addr", last_addr, 32'h0000_0100);
        chk("rd_wstrb", 32'(last_wstrb), 32'h0);
        chk("rd_len", 32'(last_len), 32'd3);
        chk("rd_resp_n", 32'(tx_log.size()), 32'd4);
        if (tx_log.size() >= 4)
            chk("rd_resp", {tx_log[0], tx_log[1], tx_log[2], tx_log[3]}, 32'h1234_5678);

        // Timeout, then the boundary cases around it
        tx_log.delete();
        send_frame(0, 32'h8000_0008, 32'h0, 0, 32'h0);
        wait_idle(500);
        chk("tmo_len", 32'(last_len), 32'd16);
        chk("tmo_resp_n", 32'(tx_log.size()), 32'd1);
        if (tx_log.size() >= 1) chk("tmo_resp", 32'(tx_log[0]), 32'h45);
        send_frame(0, 32'h0000_0040, 32'h0, TMO, 32'hA5A5_0F0F);
        send_frame(1, 32'h0000_0044, 32'h0102_0304, TMO + 1, 32'h0);
        wait_idle(800);

        // Junk bytes then a read under transmitter back-pressure
        tx_log.delete();
        b0 = bus_count;
        hold_tx = 1;
        send_junk(8'h00);
        send_junk(8'hFF);
        send_frame(0, 32'h0000_2000, 32'h0, 2, 32'hCAFE_F00D);
        n = 0;
        while (n < 500 && !(bus_count == b0 + 1 && !mem_valid)) begin
            @(negedge clk);
            n++;
        end
        chk("bp_bus_done", 32'(n < 500), 32'd1);
        repeat (100) @(negedge clk);
        chk("bp_no_tx", 32'(tx_log.size()), 32'd0);
        hold_tx = 0;
        wait_idle(500);
        chk("bp_bus_count", 32'(bus_count - b0), 32'd1);
        chk("bp_resp_n", 32'(tx_log.size()), 32'd4);

        // Reset in the middle of a write frame
        tx_log.delete();
        b0 = bus_count;
        send_junk(8'h57);
        send_junk(8'h00);
        send_junk(8'h11);
        n = 0;
        while (n < 200 && n_acks != n_pushed) begin
            @(negedge clk);
            n++;
        end
        chk("mid_acks", 32'(n_acks), 32'(n_pushed));
        repeat (2) @(negedge clk);
        chk("mid_busy", 32'(busy), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_addr", mem_addr, 32'd0);
        @(negedge clk);
        #2 reset = 1'b0;
        send_frame(0, 32'h0000_0300, 32'h0, 1, 32'h0BAD_C0DE);
        wait_idle(500);
        chk("mid_bus_count", 32'(bus_count - b0), 32'd1);
        chk("mid_wstrb", 32'(last_wstrb), 32'h0);
        chk("mid_resp_n", 32'(tx_log.size()), 32'd4);

        // rx_ready held high: a write frame takes exactly nine acks
        rx_gap = 0;
        n0 = n_acks;
        send_frame(1, 32'h0000_0500, 32'h5555_AAAA, 2, 32'h0);
        wait_idle(500);
        chk("cont_acks", 32'(n_acks - n0), 32'd9);

        // Randomized frames, junk and pacing
        for (int i = 0; i < 30; i++) begin
            int r, lat, nf;
            rx_gap = $urandom_range(60);
            tx_dmax = $urandom_range(8, 1);
            nf = $urandom_range(3, 1);
            for (int f = 0; f < nf; f++) begin
                if ($urandom_range(3) == 0) begin
                    jb = 8'($urandom());
                    if (jb == 8'h57 || jb == 8'h52) jb = 8'h00;
                    send_junk(jb);
                end
                r = $urandom_range(9);
                if (r == 0) lat = 0;
                else if (r == 1) lat = TMO;
                else if (r == 2) lat = TMO + 1;
                else lat = $urandom_range(6, 1);
                send_frame(1'($urandom_range(1)), $urandom(), $urandom(), lat, $urandom());
            end
            wait_idle(3000);
        end

        chk("all_bytes_acked", 32'(n_acks), 32'(n_pushed));
        chk("final_idle", 32'(busy), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, fail_n);
        $finish;
    end
endmodule
